// File: rtl/intersection_ctrl.sv
// Two-approach intersection controller: main road A rests on green, side road B
// and the pedestrian crossing are served on demand with yellow/all-red clearance.
module intersection_ctrl #(
  parameter int T_MIN_GREEN = 6,
  parameter int T_MAX_GREEN = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 2,
  parameter int T_WALK      = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       enable,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_req,
  output logic       a_red,
  output logic       a_yellow,
  output logic       a_green,
  output logic       b_red,
  output logic       b_yellow,
  output logic       b_green,
  output logic       walk,
  output logic [2:0] phase,
  output logic       b_pending,
  output logic       ped_pending,
  output logic [7:0] time_left
);

  typedef enum logic [2:0] {
    FLASH    = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    ALL_RED  = 3'd3,
    B_GREEN  = 3'd4,
    B_YELLOW = 3'd5,
    PED_WALK = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    NXT_A   = 2'd0,
    NXT_B   = 2'd1,
    NXT_PED = 2'd2
  } nxt_t;

  localparam logic [8:0] MIN_G = 9'(T_MIN_GREEN);
  localparam logic [8:0] MAX_G = 9'(T_MAX_GREEN);
  localparam logic [8:0] YEL   = 9'(T_YELLOW);
  localparam logic [8:0] AR    = 9'(T_ALL_RED);
  localparam logic [8:0] WLK   = 9'(T_WALK);

  phase_t      phase_r;
  nxt_t        nxt_r;
  logic [7:0]  cnt_r;
  logic        blink_r;
  logic        b_pend_r;
  logic        ped_pend_r;

  logic [8:0]  e_s;
  logic [7:0]  cnt_inc_s;
  logic        ar_done_s;
  logic        enter_b_s;
  logic        enter_ped_s;

  // Tick-count candidate and the green-entry events that clear the pendings
  always_comb begin
    e_s         = {1'b0, cnt_r} + 9'd1;
    cnt_inc_s   = (cnt_r == 8'hFF) ? 8'hFF : e_s[7:0];
    ar_done_s   = enable && tick && (phase_r == ALL_RED) && (e_s >= AR);
    enter_b_s   = ar_done_s && (nxt_r == NXT_B);
    enter_ped_s = ar_done_s && (nxt_r == NXT_PED);
  end

  // Phase sequencer, tick counter, flash blink and demand latches
  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_r    <= FLASH;
      nxt_r      <= NXT_A;
      cnt_r      <= 8'd0;
      blink_r    <= 1'b0;
      b_pend_r   <= 1'b0;
      ped_pend_r <= 1'b0;
    end else begin
      // a clear on green entry beats a same-cycle set
      if (phase_r == FLASH)                     b_pend_r <= 1'b0;
      else if (enter_b_s)                       b_pend_r <= 1'b0;
      else if (req_b && (phase_r != B_GREEN))   b_pend_r <= 1'b1;

      if (phase_r == FLASH)                     ped_pend_r <= 1'b0;
      else if (enter_ped_s)                     ped_pend_r <= 1'b0;
      else if (ped_req && (phase_r != PED_WALK)) ped_pend_r <= 1'b1;

      if ((phase_r == FLASH) && tick) blink_r <= ~blink_r;

      if (!enable || (3'(phase_r) == 3'd7)) begin
        if (phase_r != FLASH) begin
          phase_r <= FLASH;
          cnt_r   <= 8'd0;
        end else if (tick) begin
          cnt_r <= cnt_inc_s;
        end
      end else if (tick) begin
        case (phase_r)
          FLASH: begin
            phase_r <= ALL_RED;
            nxt_r   <= NXT_A;
            cnt_r   <= 8'd0;
          end
          A_GREEN: begin
            if ((e_s >= MIN_G) && (b_pend_r || ped_pend_r) && (!req_a || (e_s >= MAX_G))) begin
              phase_r <= A_YELLOW;
              cnt_r   <= 8'd0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          A_YELLOW: begin
            if (e_s >= YEL) begin
              phase_r <= ALL_RED;
              nxt_r   <= b_pend_r ? NXT_B : NXT_PED;
              cnt_r   <= 8'd0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          B_GREEN: begin
            if ((e_s >= MIN_G) && (!req_b || (e_s >= MAX_G))) begin
              phase_r <= B_YELLOW;
              cnt_r   <= 8'd0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          B_YELLOW: begin
            if (e_s >= YEL) begin
              phase_r <= ALL_RED;
              nxt_r   <= ped_pend_r ? NXT_PED : NXT_A;
              cnt_r   <= 8'd0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          PED_WALK: begin
            if (e_s >= WLK) begin
              phase_r <= ALL_RED;
              nxt_r   <= NXT_A;
              cnt_r   <= 8'd0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          ALL_RED: begin
            if (e_s >= AR) begin
              case (nxt_r)
                NXT_B:   phase_r <= B_GREEN;
                NXT_PED: phase_r <= PED_WALK;
                default: phase_r <= A_GREEN;
              endcase
              cnt_r <= 8'd0;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
          default: begin
            phase_r <= FLASH;
            cnt_r   <= 8'd0;
          end
        endcase
      end
    end
  end

  // Remaining ticks are shown only in fixed-length phases
  always_comb begin
    case (phase_r)
      A_YELLOW, B_YELLOW: time_left = 8'(T_YELLOW) - cnt_r;
      ALL_RED:            time_left = 8'(T_ALL_RED) - cnt_r;
      PED_WALK:           time_left = 8'(T_WALK) - cnt_r;
      default:            time_left = 8'd0;
    endcase
  end

  assign phase       = phase_r;
  assign b_pending   = b_pend_r;
  assign ped_pending = ped_pend_r;
  assign a_green     = (phase_r == A_GREEN);
  assign b_green     = (phase_r == B_GREEN);
  assign walk        = (phase_r == PED_WALK);
  assign a_yellow    = (phase_r == A_YELLOW) || ((phase_r == FLASH) && blink_r);
  assign b_yellow    = (phase_r == B_YELLOW) || ((phase_r == FLASH) && blink_r);
  assign a_red       = (phase_r == ALL_RED) || (phase_r == B_GREEN) ||
                       (phase_r == B_YELLOW) || (phase_r == PED_WALK);
  assign b_red       = (phase_r == ALL_RED) || (phase_r == A_GREEN) ||
                       (phase_r == A_YELLOW) || (phase_r == PED_WALK);

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized bench for intersection_ctrl, compared every cycle against a
// rule-level model of the signal plan.
module tb_intersection_ctrl;

  localparam int MING = 6;
  localparam int MAXG = 20;
  localparam int TY   = 3;
  localparam int TAR  = 2;
  localparam int TW   = 8;
  localparam int NCYC = 24000;

  localparam int P_FLASH = 0, P_AG = 1, P_AY = 2, P_AR = 3, P_BG = 4, P_BY = 5, P_PW = 6;
  localparam int S_A = 0, S_B = 1, S_PED = 2;

  logic clk, resetn, tick, enable, req_a, req_b, ped_req;
  logic a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk;
  logic [2:0] phase;
  logic b_pending, ped_pending;
  logic [7:0] time_left;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  int m_ph, m_el, m_next;
  bit m_blink, m_bp, m_pp;

  intersection_ctrl #(
    .T_MIN_GREEN(MING), .T_MAX_GREEN(MAXG), .T_YELLOW(TY), .T_ALL_RED(TAR), .T_WALK(TW)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .enable(enable),
    .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
    .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
    .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
    .walk(walk), .phase(phase), .b_pending(b_pending),
    .ped_pending(ped_pending), .time_left(time_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Length of a fixed-duration phase in ticks (0 for demand-driven phases)
  function automatic int fixed_len(input int ph);
    case (ph)
      P_AY, P_BY: return TY;
      P_AR:       return TAR;
      P_PW:       return TW;
      default:    return 0;
    endcase
  endfunction

  // Advance the reference plan by one clock using the currently applied inputs
  task automatic model_step();
    int np, nn, e;
    bit nbp, npp;
    if (!resetn) begin
      m_ph = P_FLASH; m_el = 0; m_next = S_A; m_blink = 0; m_bp = 0; m_pp = 0;
      return;
    end
    np = m_ph; nn = m_next; e = m_el + 1;
    if (!enable) begin
      np = P_FLASH;
    end else if (tick) begin
      if (m_ph == P_FLASH) begin
        np = P_AR; nn = S_A;
      end else if (m_ph == P_AG) begin
        if (e >= MING && (m_bp || m_pp) && (!req_a || e >= MAXG)) np = P_AY;
      end else if (m_ph == P_BG) begin
        if (e >= MING && (!req_b || e >= MAXG)) np = P_BY;
      end else if (e >= fixed_len(m_ph)) begin
        np = P_AR;
        if (m_ph == P_AY)      nn = m_bp ? S_B : S_PED;
        else if (m_ph == P_BY) nn = m_pp ? S_PED : S_A;
        else if (m_ph == P_PW) nn = S_A;
        else np = (m_next == S_B) ? P_BG : (m_next == S_PED) ? P_PW : P_AG;
      end
    end
    nbp = m_bp || (req_b && m_ph != P_BG);
    if (np == P_BG && m_ph != P_BG) nbp = 0;
    if (m_ph == P_FLASH) nbp = 0;
    npp = m_pp || (ped_req && m_ph != P_PW);
    if (np == P_PW && m_ph != P_PW) npp = 0;
    if (m_ph == P_FLASH) npp = 0;
    if (m_ph == P_FLASH && tick) m_blink = !m_blink;
    if (np != m_ph) m_el = 0;
    else if (tick) m_el = (e > 255) ? 255 : e;
    m_ph = np; m_next = nn; m_bp = nbp; m_pp = npp;
  endtask

  task automatic compare_all();
    logic [6:0] exp_lamps;
    int tl;
    exp_lamps[6] = (m_ph == P_AR || m_ph == P_BG || m_ph == P_BY || m_ph == P_PW);
    exp_lamps[5] = (m_ph == P_AY) || (m_ph == P_FLASH && m_blink);
    exp_lamps[4] = (m_ph == P_AG);
    exp_lamps[3] = (m_ph == P_AR || m_ph == P_AG || m_ph == P_AY || m_ph == P_PW);
    exp_lamps[2] = (m_ph == P_BY) || (m_ph == P_FLASH && m_blink);
    exp_lamps[1] = (m_ph == P_BG);
    exp_lamps[0] = (m_ph == P_PW);
    tl = (fixed_len(m_ph) > 0) ? fixed_len(m_ph) - m_el : 0;
    check("phase", 32'(phase), 32'(m_ph));
    check("lamps", 32'({a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk}), 32'(exp_lamps));
    check("pending", 32'({b_pending, ped_pending}), 32'({m_bp, m_pp}));
    check("time_left", 32'(time_left), 32'(tl));
    check("conflict", 32'((a_green && b_green) || (walk && (a_green || b_green))), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1; tick = 1'b0;
    req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;
    cyc = 0;
    model_step();
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      cyc = i;
      compare_all();
      if (n_fail > 40) break;
      ped_req = 1'b0;
      if (i < 3) begin
        resetn = 1'b0;
        tick   = (i % 4 == 0);
      end else if (i < 600) begin
        // idle plan: rest on A green with no demand
        resetn = 1'b1; enable = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        tick  = (i % 4 == 0);
      end else begin
        resetn = ($urandom_range(0, 6999) != 0);
        if (i % 5000 < 500) tick = ($urandom_range(0, 2) == 0);
        else                tick = (i % 4 == 0);
        if ($urandom_range(0, 199) == 0) req_a = ~req_a;
        if ($urandom_range(0, 179) == 0) req_b = ~req_b;
        if ($urandom_range(0, 399) == 0) req_b = 1'b1;
        ped_req = ($urandom_range(0, 159) == 0);
        if (enable) begin
          if ($urandom_range(0, 1799) == 0) enable = 1'b0;
        end else begin
          if ($urandom_range(0, 39) == 0) enable = 1'b1;
        end
      end
      model_step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
